hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. Drives the stall/flush enables of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the forwarding muxes in D and E. Also sequences two multi-cycle events: a multi-cycle multiply/divide held in E, and a data-memory handshake wait in M.

## Interface
- MDU_LATENCY, 32: cycles a mult/div instruction occupies E (≥2).
- CNT_W, 6: width of the MDU counter; must satisfy 2^CNT_W > MDU_LATENCY.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- RsD, RtD, RsE, RtE  in  5 each  source register numbers in D and E.
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register numbers per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  destination write enables.
- MemtoRegE, MemtoRegM  in  1 each  load-in-stage flags.
- BranchD, PCSrcD  in  1 each  branch in D / branch taken.
- mdu_start_e  in  1  mult/div instruction present in E.
- mem_req_m, mem_ready_m  in  1 each  data-memory request and completion.
- ForwardAE, ForwardBE  out  2 each  E operand select.
- ForwardAD, ForwardBD  out  1 each  D branch-compare forward from M.
- StallF, StallD, StallE, StallM  out  1 each  hold the pipeline register.
- FlushD, FlushE, FlushM, FlushW  out  1 each  insert a bubble.

## Operation
- Forwarding (combinational): ForwardAE = 2'b10 if RegWriteM && WriteRegM!=0 && WriteRegM==RsE; else 2'b01 if the same test on W matches; else 2'b00. ForwardBE is identical with RtE. ForwardAD = RegWriteM && WriteRegM!=0 && WriteRegM==RsD. ForwardBD uses RtD.
- lwstall = MemtoRegE && WriteRegE!=0 && (WriteRegE==RsD || WriteRegE==RtD).
- brstall = BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM!=0 && WriteRegM∈{RsD,RtD})).
- memstall = mem_req_m && !mem_ready_m.
- MDU FSM, states IDLE and MDU_BUSY, with counter cnt[CNT_W-1:0]:
  - IDLE with mdu_start_e: load cnt = MDU_LATENCY-2 and go to MDU_BUSY.
  - MDU_BUSY with cnt!=0: decrement cnt.
  - MDU_BUSY with cnt==0: go to IDLE.
  - mdu_start_e is ignored outside IDLE.
  - The counter runs regardless of memstall.
- mdubusy = (IDLE && mdu_start_e) || (MDU_BUSY && cnt!=0).
- Output priority, highest first:
  1. Reset: while rst_n==0, all Stall*=0, all Flush*=1, Forward*=0.
  2. memstall: StallF/D/E/M=1, FlushW=1, other flushes 0.
  3. mdubusy: StallF/D/E=1, FlushM=1, StallM=0.
  4. lwstall || brstall: StallF/D=1, FlushE=1.
  5. Otherwise all stalls 0.
- FlushD = PCSrcD && !StallD, evaluated outside reset only.

## Timing
- Forwarding, stall and flush outputs are combinational, valid in the same cycle as their inputs. The only state is the FSM and cnt.
- An MDU instruction issued (first seen in E in IDLE) at cycle t asserts StallE on cycles t..t+MDU_LATENCY-2. It leaves E at the edge ending cycle t+MDU_LATENCY-1, so it occupies E for exactly MDU_LATENCY cycles when there is no memstall.
- memstall overlapping the MDU window extends the hold until mem_ready_m. The FSM can return to IDLE during the wait and mdu_start_e stays high, so the next IDLE cycle re-triggers.
  - Downstream must deassert mdu_start_e once its operation completes.
  - Tests check that completion happens at MDU_LATENCY with no memstall.
- Reset values: state=IDLE, cnt=0. Reset asserted mid-MDU returns to IDLE at the next edge.
- lwstall costs exactly one bubble. brstall lasts one cycle for an E producer and one more for a load in M.

## Structure
- hazard_pkg: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; the FSM state enum (IDLE, MDU_BUSY).
- Sub-module mdu_timer: holds the FSM and counter, and outputs mdubusy. hazard_ctrl holds the forwarding and priority logic.

## Test plan
- RegWriteM=1, WriteRegM=8, RsE=8, and RegWriteW=1, WriteRegW=8 → ForwardAE=2'b10. With WriteRegM=0 and everything else unchanged → ForwardAE=2'b01.
- MemtoRegE=1, WriteRegE=9, RtD=9 → StallF=StallD=FlushE=1 for one cycle. WriteRegE=0 → no stall.
- MDU_LATENCY=4, mdu_start_e held from cycle t → StallE=1 on t..t+2, 0 on t+3; FlushM=1 on t..t+2.
- mem_req_m=1, mem_ready_m=0 for 3 cycles during lwstall → StallM=1, FlushW=1, FlushE=0 for those 3 cycles; lwstall bubble follows the wait.
- rst_n=0 for one edge at cnt=5 in MDU_BUSY → state=IDLE, cnt=0. During reset, all Flush*=1 and Stall*=0.
- BranchD=1, MemtoRegM=1, WriteRegM=3, RsD=3 → StallD=1, FlushE=1. With PCSrcD=1 and no stall → FlushD=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   FWD_RF / FWD_WB / FWD_MEM : E-stage operand mux selects
//   mdu_state_t               : multi-cycle multiply/divide sequencer states
//   fwd_sel()                 : E-stage forward select for one source register
// ---------------------------------------------------------------------------
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
   localparam logic [1:0] FWD_WB  = 2'b01;  // operand from the W-stage result
   localparam logic [1:0] FWD_MEM = 2'b10;  // operand from the M-stage ALU result

   typedef enum logic {
      IDLE     = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_t;

   // The M stage holds the younger result, so it is checked before W.
   // Register 0 is hardwired to zero and is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic       reg_write_m,
      input logic [4:0] write_reg_m,
      input logic       reg_write_w,
      input logic [4:0] write_reg_w
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == src))
         sel = FWD_MEM;
      else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == src))
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle of every signal exchanged between the pipeline datapath and the
// hazard controller (clock and reset stay outside).
//   master : the pipeline side; drives register numbers, enables and the
//            MDU / data-memory status, receives stall/flush/forward controls.
//   slave  : the hazard controller.
// Data-memory handshake: a request is outstanding in M while mem_req_m is
// high; it completes in the cycle mem_ready_m is also high. Until then the
// whole pipeline from F to M is held.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;

   logic [4:0] RsD, RtD, RsE, RtE;
   logic [4:0] WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic       MemtoRegE, MemtoRegM;
   logic       BranchD, PCSrcD;
   logic       mdu_start_e;
   logic       mem_req_m, mem_ready_m;

   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD;
   logic       StallF, StallD, StallE, StallM;
   logic       FlushD, FlushE, FlushM, FlushW;

   modport master (
      output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
             BranchD, PCSrcD, mdu_start_e, mem_req_m, mem_ready_m,
      input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
             StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushM, FlushW
   );

   modport slave (
      input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
             BranchD, PCSrcD, mdu_start_e, mem_req_m, mem_ready_m,
      output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
             StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushM, FlushW
   );

endinterface

// File: rtl/hazard_ctrl_mdu_timer.sv
// ---------------------------------------------------------------------------
// mdu_timer
// Sequences a multi-cycle multiply/divide held in the E stage.
// Ports:
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   i_start    : mult/div instruction present in E
//   o_busy     : E must be held this cycle
//   o_state    : current FSM state (debug)
//   o_cnt      : current counter value (debug)
// An instruction first seen in IDLE loads MDU_LATENCY-2 and is held for
// MDU_LATENCY-1 cycles; the cycle with cnt==0 is its last cycle in E.
// ---------------------------------------------------------------------------
module mdu_timer
   import hazard_pkg::*;
#(
   parameter int MDU_LATENCY = 32,
   parameter int CNT_W       = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   output logic             o_busy,
   output mdu_state_t       o_state,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 2);

   mdu_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   mdu_state_t       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_busy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // The counter advances every cycle, independent of any memory wait.
   // i_start is only looked at in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_busy      = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt = MDU_BUSY;
               w_cnt_nxt   = CNT_LOAD;
               w_busy      = 1'b1;
            end
         end
         MDU_BUSY: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
               w_busy    = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_busy  = w_busy;
   assign o_state = r_state;
   assign o_cnt   = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard, stall and forwarding controller for the 5-stage MIPS pipeline.
// Ports:
//   clk, rst_n   : rising-edge clock, synchronous active-low reset
//   hz (slave)   : pipeline register numbers / enables in, stall, flush and
//                  forward controls out (all outputs combinational)
//   o_dbg_state  : MDU sequencer state
//   o_dbg_cnt    : MDU sequencer counter
// Stall priority, highest first: reset, memory wait, MDU busy,
// load-use / branch-compare hazard.
// ---------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MDU_LATENCY = 32,
   parameter int CNT_W       = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   hazard_ctrl_if.slave     hz,
   output mdu_state_t       o_dbg_state,
   output logic [CNT_W-1:0] o_dbg_cnt
);

   logic w_lwstall;
   logic w_brstall;
   logic w_memstall;
   logic w_mdubusy;
   logic w_br_e_dep;
   logic w_br_m_dep;

   mdu_timer #(
      .MDU_LATENCY (MDU_LATENCY),
      .CNT_W       (CNT_W)
   ) u_mdu_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (hz.mdu_start_e),
      .o_busy  (w_mdubusy),
      .o_state (o_dbg_state),
      .o_cnt   (o_dbg_cnt)
   );

   // Load in E whose result a D-stage source needs: one bubble.
   assign w_lwstall = hz.MemtoRegE && (hz.WriteRegE != 5'd0) &&
                      ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD));

   // The branch compares in D, so an ALU result still in E, or a load
   // result still in M, is not yet forwardable.
   assign w_br_e_dep = hz.RegWriteE && (hz.WriteRegE != 5'd0) &&
                       ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD));
   assign w_br_m_dep = hz.MemtoRegM && (hz.WriteRegM != 5'd0) &&
                       ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD));
   assign w_brstall  = hz.BranchD && (w_br_e_dep || w_br_m_dep);

   assign w_memstall = hz.mem_req_m && !hz.mem_ready_m;

   always_comb begin
      hz.ForwardAE = FWD_RF;
      hz.ForwardBE = FWD_RF;
      hz.ForwardAD = 1'b0;
      hz.ForwardBD = 1'b0;
      hz.StallF    = 1'b0;
      hz.StallD    = 1'b0;
      hz.StallE    = 1'b0;
      hz.StallM    = 1'b0;
      hz.FlushD    = 1'b0;
      hz.FlushE    = 1'b0;
      hz.FlushM    = 1'b0;
      hz.FlushW    = 1'b0;

      if (!rst_n) begin
         // Bubble every stage while reset is held.
         hz.FlushD = 1'b1;
         hz.FlushE = 1'b1;
         hz.FlushM = 1'b1;
         hz.FlushW = 1'b1;
      end else begin
         hz.ForwardAE = fwd_sel(hz.RsE, hz.RegWriteM, hz.WriteRegM,
                                hz.RegWriteW, hz.WriteRegW);
         hz.ForwardBE = fwd_sel(hz.RtE, hz.RegWriteM, hz.WriteRegM,
                                hz.RegWriteW, hz.WriteRegW);
         hz.ForwardAD = hz.RegWriteM && (hz.WriteRegM != 5'd0) &&
                        (hz.WriteRegM == hz.RsD);
         hz.ForwardBD = hz.RegWriteM && (hz.WriteRegM != 5'd0) &&
                        (hz.WriteRegM == hz.RtD);

         if (w_memstall) begin
            // M is frozen; W receives a bubble so nothing retires twice.
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
         end else if (w_mdubusy) begin
            // E is held; M receives a bubble while W drains normally.
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.FlushM = 1'b1;
         end else if (w_lwstall || w_brstall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
         end

         // A taken branch squashes the fetched instruction only when D moves.
         hz.FlushD = hz.PCSrcD && !hz.StallD;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Inputs change 1 time unit after a rising
// edge; outputs are sampled on the falling edge.
// Stall vector = {StallF,StallD,StallE,StallM}
// Flush vector = {FlushD,FlushE,FlushM,FlushW}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
   import hazard_pkg::*;

   localparam int LAT = 8;
   localparam int CW  = 4;

   logic          clk;
   logic          rst_n;
   mdu_state_t    dbg_state;
   logic [CW-1:0] dbg_cnt;

   int n_cmp;
   int n_err;

   hazard_ctrl_if hif ();

   hazard_ctrl #(
      .MDU_LATENCY (LAT),
      .CNT_W       (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hz          (hif),
      .o_dbg_state (dbg_state),
      .o_dbg_cnt   (dbg_cnt)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [3:0] stall_v = {hif.StallF, hif.StallD, hif.StallE, hif.StallM};
   wire [3:0] flush_v = {hif.FlushD, hif.FlushE, hif.FlushM, hif.FlushW};

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      hif.RsD = 5'd0; hif.RtD = 5'd0; hif.RsE = 5'd0; hif.RtE = 5'd0;
      hif.WriteRegE = 5'd0; hif.WriteRegM = 5'd0; hif.WriteRegW = 5'd0;
      hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
      hif.MemtoRegE = 1'b0; hif.MemtoRegM = 1'b0;
      hif.BranchD = 1'b0; hif.PCSrcD = 1'b0;
      hif.mdu_start_e = 1'b0;
      hif.mem_req_m = 1'b0; hif.mem_ready_m = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      hif.PCSrcD = 1'b1;
      hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd4; hif.RsE = 5'd4; hif.RsD = 5'd4;
      hif.mem_req_m = 1'b1;
      sample();
      n_cmp++;
      if (stall_v !== 4'b0000) begin
         n_err++; $display("FAIL reset_stall: got %b want 0000", stall_v);
      end
      n_cmp++;
      if (flush_v !== 4'b1111) begin
         n_err++; $display("FAIL reset_flush: got %b want 1111", flush_v);
      end
      n_cmp++;
      if (hif.ForwardAE !== 2'b00 || hif.ForwardAD !== 1'b0) begin
         n_err++; $display("FAIL reset_fwd: got AE=%b AD=%b want 00/0", hif.ForwardAE, hif.ForwardAD);
      end
      tick();
      n_cmp++;
      if (dbg_state !== IDLE || dbg_cnt !== 4'd0) begin
         n_err++; $display("FAIL reset_state: got state=%0d cnt=%0d want 0/0", dbg_state, dbg_cnt);
      end
      rst_n = 1'b1;
      clear_inputs();
      tick();
   endtask

   task automatic test_forward();
      clear_inputs();
      hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd8; hif.RsE = 5'd8; hif.RtE = 5'd8;
      hif.RegWriteW = 1'b1; hif.WriteRegW = 5'd8;
      hif.RsD = 5'd8; hif.RtD = 5'd9;
      sample();
      n_cmp++;
      if (hif.ForwardAE !== 2'b10) begin
         n_err++; $display("FAIL fwd_ae_mem: got %b want 10", hif.ForwardAE);
      end
      n_cmp++;
      if (hif.ForwardBE !== 2'b10) begin
         n_err++; $display("FAIL fwd_be_mem: got %b want 10", hif.ForwardBE);
      end
      n_cmp++;
      if (hif.ForwardAD !== 1'b1 || hif.ForwardBD !== 1'b0) begin
         n_err++; $display("FAIL fwd_d: got AD=%b BD=%b want 1/0", hif.ForwardAD, hif.ForwardBD);
      end
      tick();
      hif.WriteRegM = 5'd0;
      sample();
      n_cmp++;
      if (hif.ForwardAE !== 2'b01) begin
         n_err++; $display("FAIL fwd_ae_wb: got %b want 01", hif.ForwardAE);
      end
      n_cmp++;
      if (hif.ForwardAD !== 1'b0) begin
         n_err++; $display("FAIL fwd_ad_r0: got %b want 0", hif.ForwardAD);
      end
      tick();
      hif.RegWriteW = 1'b0;
      sample();
      n_cmp++;
      if (hif.ForwardAE !== 2'b00 || hif.ForwardBE !== 2'b00) begin
         n_err++; $display("FAIL fwd_none: got AE=%b BE=%b want 00/00", hif.ForwardAE, hif.ForwardBE);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_lwstall();
      clear_inputs();
      hif.MemtoRegE = 1'b1; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd9; hif.RtD = 5'd9;
      sample();
      n_cmp++;
      if (stall_v !== 4'b1100 || flush_v !== 4'b0100) begin
         n_err++; $display("FAIL lw_bubble: got stall=%b flush=%b want 1100/0100", stall_v, flush_v);
      end
      // Load has moved to M; D is no longer blocked.
      tick();
      hif.MemtoRegE = 1'b0; hif.RegWriteE = 1'b0; hif.WriteRegE = 5'd0;
      hif.MemtoRegM = 1'b1; hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd9;
      sample();
      n_cmp++;
      if (stall_v !== 4'b0000 || flush_v !== 4'b0000) begin
         n_err++; $display("FAIL lw_after: got stall=%b flush=%b want 0000/0000", stall_v, flush_v);
      end
      tick();
      clear_inputs();
      hif.MemtoRegE = 1'b1; hif.WriteRegE = 5'd0; hif.RtD = 5'd0; hif.RsD = 5'd0;
      sample();
      n_cmp++;
      if (stall_v !== 4'b0000 || flush_v !== 4'b0000) begin
         n_err++; $display("FAIL lw_r0: got stall=%b flush=%b want 0000/0000", stall_v, flush_v);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_brstall();
      clear_inputs();
      hif.BranchD = 1'b1; hif.PCSrcD = 1'b1;
      hif.MemtoRegM = 1'b1; hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd3; hif.RsD = 5'd3;
      sample();
      n_cmp++;
      if (stall_v !== 4'b1100 || flush_v !== 4'b0100) begin
         n_err++; $display("FAIL br_load_m: got stall=%b flush=%b want 1100/0100", stall_v, flush_v);
      end
      tick();
      hif.MemtoRegM = 1'b0;
      sample();
      n_cmp++;
      if (stall_v !== 4'b0000 || flush_v !== 4'b1000) begin
         n_err++; $display("FAIL br_taken: got stall=%b flush=%b want 0000/1000", stall_v, flush_v);
      end
      n_cmp++;
      if (hif.ForwardAD !== 1'b1) begin
         n_err++; $display("FAIL br_fwd_ad: got %b want 1", hif.ForwardAD);
      end
      tick();
      clear_inputs();
      hif.BranchD = 1'b1; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd5; hif.RtD = 5'd5;
      sample();
      n_cmp++;
      if (stall_v !== 4'b1100 || flush_v !== 4'b0100) begin
         n_err++; $display("FAIL br_alu_e: got stall=%b flush=%b want 1100/0100", stall_v, flush_v);
      end
      tick();
      hif.BranchD = 1'b0;
      sample();
      n_cmp++;
      if (stall_v !== 4'b0000) begin
         n_err++; $display("FAIL br_nobranch: got stall=%b want 0000", stall_v);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_mdu();
      logic [3:0] exp_s;
      logic [3:0] exp_f;
      clear_inputs();
      hif.mdu_start_e = 1'b1;
      for (int k = 0; k < LAT; k++) begin
         sample();
         exp_s = (k <= LAT - 2) ? 4'b1110 : 4'b0000;
         exp_f = (k <= LAT - 2) ? 4'b0010 : 4'b0000;
         n_cmp++;
         if (stall_v !== exp_s || flush_v !== exp_f) begin
            n_err++; $display("FAIL mdu_cycle%0d: got stall=%b flush=%b want %b/%b", k, stall_v, flush_v, exp_s, exp_f);
         end
         if (k >= 1) begin
            n_cmp++;
            if (dbg_state !== MDU_BUSY || dbg_cnt !== CW'(LAT - 1 - k)) begin
               n_err++; $display("FAIL mdu_cnt%0d: got state=%0d cnt=%0d want 1/%0d", k, dbg_state, dbg_cnt, LAT - 1 - k);
            end
         end
         if (k == LAT - 1) hif.mdu_start_e = 1'b0;
         tick();
      end
      sample();
      n_cmp++;
      if (dbg_state !== IDLE || stall_v !== 4'b0000) begin
         n_err++; $display("FAIL mdu_done: got state=%0d stall=%b want 0/0000", dbg_state, stall_v);
      end
      tick();
   endtask

   task automatic test_memstall();
      clear_inputs();
      hif.MemtoRegE = 1'b1; hif.WriteRegE = 5'd9; hif.RtD = 5'd9; hif.PCSrcD = 1'b1;
      hif.mem_req_m = 1'b1; hif.mem_ready_m = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample();
         n_cmp++;
         if (stall_v !== 4'b1111 || flush_v !== 4'b0001) begin
            n_err++; $display("FAIL mem_wait%0d: got stall=%b flush=%b want 1111/0001", k, stall_v, flush_v);
         end
         tick();
      end
      hif.mem_ready_m = 1'b1; hif.PCSrcD = 1'b0;
      sample();
      n_cmp++;
      if (stall_v !== 4'b1100 || flush_v !== 4'b0100) begin
         n_err++; $display("FAIL mem_then_lw: got stall=%b flush=%b want 1100/0100", stall_v, flush_v);
      end
      tick();
      clear_inputs();
      sample();
      n_cmp++;
      if (stall_v !== 4'b0000 || flush_v !== 4'b0000) begin
         n_err++; $display("FAIL mem_clear: got stall=%b flush=%b want 0000/0000", stall_v, flush_v);
      end
      tick();
   endtask

   task automatic test_mdu_memstall();
      clear_inputs();
      hif.mdu_start_e = 1'b1; hif.mem_req_m = 1'b1; hif.mem_ready_m = 1'b0;
      sample();
      n_cmp++;
      if (stall_v !== 4'b1111 || flush_v !== 4'b0001) begin
         n_err++; $display("FAIL mdumem_wait: got stall=%b flush=%b want 1111/0001", stall_v, flush_v);
      end
      tick();
      sample();
      n_cmp++;
      if (dbg_state !== MDU_BUSY || dbg_cnt !== CW'(LAT - 2)) begin
         n_err++; $display("FAIL mdumem_load: got state=%0d cnt=%0d want 1/%0d", dbg_state, dbg_cnt, LAT - 2);
      end
      tick();
      hif.mem_req_m = 1'b0;
      sample();
      n_cmp++;
      if (stall_v !== 4'b1110 || flush_v !== 4'b0010 || dbg_cnt !== CW'(LAT - 3)) begin
         n_err++; $display("FAIL mdumem_run: got stall=%b flush=%b cnt=%0d want 1110/0010/%0d", stall_v, flush_v, dbg_cnt, LAT - 3);
      end
      // Abort the operation through reset.
      hif.mdu_start_e = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_mdu_reset();
      clear_inputs();
      hif.mdu_start_e = 1'b1;
      tick();
      hif.mdu_start_e = 1'b0;
      tick();
      sample();
      n_cmp++;
      if (dbg_state !== MDU_BUSY || dbg_cnt !== 4'd5) begin
         n_err++; $display("FAIL mdurst_pre: got state=%0d cnt=%0d want 1/5", dbg_state, dbg_cnt);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (stall_v !== 4'b0000 || flush_v !== 4'b1111) begin
         n_err++; $display("FAIL mdurst_out: got stall=%b flush=%b want 0000/1111", stall_v, flush_v);
      end
      tick();
      rst_n = 1'b1;
      sample();
      n_cmp++;
      if (dbg_state !== IDLE || dbg_cnt !== 4'd0 || stall_v !== 4'b0000) begin
         n_err++; $display("FAIL mdurst_post: got state=%0d cnt=%0d stall=%b want 0/0/0000", dbg_state, dbg_cnt, stall_v);
      end
      tick();
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      clear_inputs();
      tick();
      test_reset();
      test_forward();
      test_lwstall();
      test_brstall();
      test_mdu();
      test_memstall();
      test_mdu_memstall();
      test_mdu_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
